line_follower_ctrl: RTL

//   Parametrised line-follower controller: N reflective sensors in, two PWM+direction motor drives out.

---
 rtl/line_follower_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/line_follower_ctrl.sv
// line_follower_ctrl: debounced N-sensor line follower driving two soft-start, reverse-protected PWM H-bridge channels
module line_follower_ctrl #(
  parameter int N_SENS       = 3,
  parameter int PWM_W        = 8,
  parameter int DEB_CYCLES   = 4,
  parameter int RAMP_STEP    = 8,
  parameter int SPEED_FWD    = 200,
  parameter int SPEED_TURN   = 120,
  parameter int LOST_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_SENS-1:0] sens,
  output logic              pwm_l,
  output logic              ml_fwd,
  output logic              ml_rev,
  output logic              pwm_r,
  output logic              mr_fwd,
  output logic              mr_rev,
  output logic [2:0]        state,
  output logic              lost
);
  localparam int C  = (N_SENS - 1) / 2;
  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam int LW = $clog2(LOST_TIMEOUT) + 1;
  localparam logic [PWM_W-1:0] STEP    = PWM_W'(RAMP_STEP);
  localparam logic [PWM_W-1:0] SP_FWD  = PWM_W'(SPEED_FWD);
  localparam logic [PWM_W-1:0] SP_TURN = PWM_W'(SPEED_TURN);
  typedef enum logic [2:0] {IDLE = 3'd0, FWD = 3'd1, LEFT = 3'd2, RIGHT = 3'd3, SEARCH = 3'd4, STOP = 3'd5} state_t;
  state_t st, nxt, dec;
  logic [N_SENS-1:0] s1, s2, stable;
  logic [DW-1:0] deb [N_SENS];
  logic [PWM_W-1:0] cnt, duty_l, duty_r, tgt_l, tgt_r;
  logic [1:0] dir_l, dir_r, req_l, req_r;
  logic [LW-1:0] lost_cnt;
  logic last_dir, l, r, none, pstart, timeout, run;
  function automatic logic [PWM_W-1:0] ramp(input logic [PWM_W-1:0] d, input logic [PWM_W-1:0] t);
    return (d < t) ? ((t - d > STEP) ? d + STEP : t) : ((d - t > STEP) ? d - STEP : t);
  endfunction
  // direction only flips once the wheel has ramped down to zero duty
  function automatic logic [PWM_W+1:0] motor(input logic [1:0] dir, input logic [PWM_W-1:0] duty,
                                             input logic [1:0] req, input logic [PWM_W-1:0] tgt);
    return (dir != req) ? ((duty == '0) ? {req, duty} : {dir, ramp(duty, '0)}) : {dir, ramp(duty, tgt)};
  endfunction
  // two-flop synchroniser on the asynchronous sensor pins
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sens;
      s2 <= s1;
    end
  // per-bit debounce: accept the new level after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < N_SENS; i++) deb[i] <= '0;
    end else begin
      for (int i = 0; i < N_SENS; i++)
        if (s2[i] == stable[i]) deb[i] <= '0;
        else if (deb[i] == DW'(DEB_CYCLES - 1)) begin
          stable[i] <= s2[i];
          deb[i] <= '0;
        end else deb[i] <= deb[i] + 1'b1;
    end
  // free-running PWM counter; a period starts at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= cnt + 1'b1;
  // sensor decode, next state and per-wheel direction/speed targets
  always_comb begin
    l = |stable[C-1:0];
    r = |stable[N_SENS-1:C+1];
    none = ~|stable;
    pstart = cnt == '0;
    run = st != IDLE && st != STOP;
    timeout = st == SEARCH && none && pstart && lost_cnt == LW'(LOST_TIMEOUT - 1);
    dec = &stable ? STOP : none ? SEARCH : (l && !r) ? LEFT : (r && !l) ? RIGHT : FWD;
    nxt = !en ? IDLE : (st == IDLE) ? FWD : (st == STOP) ? STOP :
          (st == SEARCH && none) ? (timeout ? STOP : SEARCH) : dec;
    req_l = (st == SEARCH && !last_dir) ? 2'b01 : 2'b10;
    req_r = (st == SEARCH && last_dir) ? 2'b01 : 2'b10;
    tgt_l = (st == LEFT || st == SEARCH) ? SP_TURN : SP_FWD;
    tgt_r = (st == RIGHT || st == SEARCH) ? SP_TURN : SP_FWD;
  end
  // steering state, last turn direction and search timeout bookkeeping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      last_dir <= 1'b0;
      lost_cnt <= '0;
      lost <= 1'b0;
    end else begin
      st <= nxt;
      last_dir <= (nxt == RIGHT) ? 1'b1 : (nxt == LEFT) ? 1'b0 : last_dir;
      lost_cnt <= (st == SEARCH && nxt == SEARCH) ? lost_cnt + LW'(pstart) : '0;
      lost <= (nxt != IDLE) && (lost || timeout);
    end
  // duty ramping and direction changes happen only at period starts; idle/stop clear at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {dir_l, duty_l} <= '0;
      {dir_r, duty_r} <= '0;
    end else if (!run) begin
      {dir_l, duty_l} <= '0;
      {dir_r, duty_r} <= '0;
    end else if (pstart) begin
      {dir_l, duty_l} <= motor(dir_l, duty_l, req_l, tgt_l);
      {dir_r, duty_r} <= motor(dir_r, duty_r, req_r, tgt_r);
    end
  assign pwm_l  = run && (cnt < duty_l);
  assign ml_fwd = run && dir_l[1];
  assign ml_rev = run && dir_l[0];
  assign pwm_r  = run && (cnt < duty_r);
  assign mr_fwd = run && dir_r[1];
  assign mr_rev = run && dir_r[0];
  assign state  = st;
endmodule
